// File: rtl/i2s_tdm_pkg.sv
// Shared definitions for the I2S/TDM link blocks: frame-alignment state and sizing helpers.
package i2s_tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } frame_state_e;

  // Frame length in bits for a given slot width and slot count.
  function automatic int unsigned frame_len(input int unsigned bits, input int unsigned slots);
    return bits * slots;
  endfunction

  // Width of a counter that indexes every bit of an n-bit frame.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_rx_sync_edge.sv
// Two-flop synchronizer with an optional third flop for rising-edge detection.
module sync_edge #(
  parameter bit G_EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

  generate
    if (G_EDGE) begin : g_edge
      logic s3;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s3 <= 1'b0;
        else        s3 <= s2;
      end
      assign rise_c = s2 & ~s3;
    end else begin : g_no_edge
      assign rise_c = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/tdm_rx.sv
// TDM link receiver: oversamples sclk/fclk/din, aligns on frame sync and
// presents each complete frame with a one-cycle strobe.
module tdm_rx
  import i2s_tdm_pkg::*;
#(
  parameter int unsigned G_BITS  = 16,
  parameter int unsigned G_SLOTS = 8
) (
  input  logic                        in_mclk,
  input  logic                        in_rst_n,
  input  logic                        in_sclk,
  input  logic                        in_fclk,
  input  logic                        in_din,
  output logic [G_BITS*G_SLOTS-1:0]   out_frames,
  output logic                        out_frame_strobe,
  output logic                        out_locked,
  output logic                        out_error
);

  localparam int unsigned N  = frame_len(G_BITS, G_SLOTS);
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  logic [1:0]    rst_pipe;
  logic          rst_n_int;
  logic          bit_event_c;
  logic          fclk_s;
  logic          din_s;
  logic          fclk_rise_unused;
  logic          din_rise_unused;
  logic          fs_c;
  logic [N-1:0]  shreg_next_c;

  frame_state_e  state;
  logic [CW-1:0] bit_cnt;
  logic [N-1:0]  shreg;
  logic          fclk_prev;

  // Reset asserts immediately but releases on an mclk edge.
  always_ff @(posedge in_mclk or negedge in_rst_n) begin
    if (!in_rst_n) rst_pipe <= 2'b00;
    else           rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n_int = rst_pipe[1];

  sync_edge #(.G_EDGE(1'b1)) u_sync_sclk (
    .clk    (in_mclk),
    .rst_n  (rst_n_int),
    .d      (in_sclk),
    .q      (),
    .rise_c (bit_event_c)
  );

  sync_edge #(.G_EDGE(1'b0)) u_sync_fclk (
    .clk    (in_mclk),
    .rst_n  (rst_n_int),
    .d      (in_fclk),
    .q      (fclk_s),
    .rise_c (fclk_rise_unused)
  );

  sync_edge #(.G_EDGE(1'b0)) u_sync_din (
    .clk    (in_mclk),
    .rst_n  (rst_n_int),
    .d      (in_din),
    .q      (din_s),
    .rise_c (din_rise_unused)
  );

  // fclk_prev only advances on bit events, so a wide fclk still yields one fs.
  assign fs_c         = fclk_s & ~fclk_prev;
  assign shreg_next_c = {shreg[N-2:0], din_s};

  always_ff @(posedge in_mclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state            <= HUNT;
      bit_cnt          <= '0;
      shreg            <= '0;
      fclk_prev        <= 1'b0;
      out_frames       <= '0;
      out_frame_strobe <= 1'b0;
      out_error        <= 1'b0;
    end else begin
      out_frame_strobe <= 1'b0;
      out_error        <= 1'b0;
      if (bit_event_c) begin
        fclk_prev <= fclk_s;
        shreg     <= shreg_next_c;
        case (state)
          HUNT: begin
            if (fs_c) begin
              state   <= LOCKED;
              bit_cnt <= '0;
            end
          end
          LOCKED: begin
            if (fs_c) begin
              bit_cnt <= '0;
              if (bit_cnt == LAST_BIT) begin
                out_frames       <= shreg_next_c;
                out_frame_strobe <= 1'b1;
              end else begin
                out_error <= 1'b1;
              end
            end else if (bit_cnt == LAST_BIT) begin
              out_error <= 1'b1;
              state     <= HUNT;
              bit_cnt   <= '0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign out_locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_rx.sv
// Randomized bench for tdm_rx: drives a serial TDM link and checks received
// frames and framing errors against a frame-level reference model.
`timescale 1ns/1ps
module tb_tdm_rx;

  localparam int unsigned G_BITS  = 16;
  localparam int unsigned G_SLOTS = 8;
  localparam int unsigned N       = G_BITS * G_SLOTS;
  localparam int unsigned T_SCLK  = 40;

  logic         in_mclk = 1'b0;
  logic         in_rst_n = 1'b0;
  logic         in_sclk = 1'b0;
  logic         in_fclk = 1'b0;
  logic         in_din = 1'b0;
  logic [N-1:0] out_frames;
  logic         out_frame_strobe;
  logic         out_locked;
  logic         out_error;

  tdm_rx #(.G_BITS(G_BITS), .G_SLOTS(G_SLOTS)) dut (
    .in_mclk          (in_mclk),
    .in_rst_n         (in_rst_n),
    .in_sclk          (in_sclk),
    .in_fclk          (in_fclk),
    .in_din           (in_din),
    .out_frames       (out_frames),
    .out_frame_strobe (out_frame_strobe),
    .out_locked       (out_locked),
    .out_error        (out_error)
  );

  always #5 in_mclk = ~in_mclk;

  typedef struct {
    logic         is_err;
    logic [N-1:0] frame;
  } ev_t;

  int  total = 0;
  int  bad = 0;
  int  both_cnt = 0;
  int  wide_cnt = 0;
  bit  prev_stb = 1'b0;
  bit  prev_err = 1'b0;
  bit  din_q[$];
  bit  fs_q[$];
  bit  fclk_a[$];
  ev_t exp_q[$];
  ev_t obs_q[$];
  time stb_t[$];

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge in_mclk) begin
    if (out_frame_strobe && out_error) both_cnt++;
    if ((out_frame_strobe && prev_stb) || (out_error && prev_err)) wide_cnt++;
    prev_stb = out_frame_strobe;
    prev_err = out_error;
    if (out_frame_strobe) begin
      obs_q.push_back('{1'b0, out_frames});
      stb_t.push_back($time);
    end
    if (out_error) obs_q.push_back('{1'b1, '0});
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bit(input bit b, input bit f);
    din_q.push_back(b);
    fs_q.push_back(f);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_bit(1'($urandom), 1'b0);
  endtask

  task automatic push_sync();
    push_bit(1'($urandom), 1'b1);
  endtask

  // MSB first; optionally marks the last bit as carrying the next frame sync.
  task automatic push_frame(input logic [N-1:0] f, input bit fs_last);
    for (int i = N - 1; i >= 0; i--) push_bit(f[i], fs_last && (i == 0));
  endtask

  function automatic logic [N-1:0] rand_frame();
    logic [N-1:0] f = '0;
    for (int i = 0; i < int'(N / 32); i++) f = (f << 32) | N'($urandom);
    return f;
  endfunction

  // fclk high from each sync bit for 1 bit or half a frame, always low the bit before the next sync.
  task automatic build_fclk(input bit wide);
    int len = din_q.size();
    int w = wide ? int'(N / 2) : 1;
    fclk_a = {};
    for (int i = 0; i < len; i++) fclk_a.push_back(1'b0);
    for (int p = 0; p < len; p++) begin
      if (fs_q[p]) begin
        for (int k = 0; k < w; k++) begin
          if (p + k >= len) break;
          if (k > 0 && fs_q[p + k]) break;
          if (p + k + 1 < len && fs_q[p + k + 1]) break;
          fclk_a[p + k] = 1'b1;
        end
      end
    end
  endtask

  // Each sync followed by another exactly N bits later yields a frame; any other spacing is an error.
  task automatic compute_expect();
    int fsp[$];
    int len = din_q.size();
    ev_t e;
    for (int i = 0; i < len; i++) if (fs_q[i]) fsp.push_back(i);
    for (int j = 0; j < fsp.size(); j++) begin
      int p = fsp[j];
      e.is_err = 1'b1;
      e.frame  = '0;
      if (j + 1 < fsp.size()) begin
        int q = fsp[j + 1];
        if (q - p == int'(N)) begin
          e.is_err = 1'b0;
          for (int i = p + 1; i <= q; i++) e.frame = {e.frame[N-2:0], din_q[i]};
        end
        exp_q.push_back(e);
      end else if (len - 1 - p >= int'(N)) begin
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_range(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      in_sclk = 1'b0;
      in_din  = din_q[i];
      in_fclk = fclk_a[i];
      #(T_SCLK / 2);
      in_sclk = 1'b1;
      #(T_SCLK / 2);
    end
  endtask

  task automatic settle();
    #100;
  endtask

  task automatic new_segment();
    din_q = {}; fs_q = {}; fclk_a = {};
    exp_q = {}; obs_q = {}; stb_t = {};
  endtask

  task automatic do_reset();
    in_sclk  = 1'b0;
    in_fclk  = 1'b0;
    in_din   = 1'b0;
    in_rst_n = 1'b0;
    #40;
    in_rst_n = 1'b1;
    #40;
    new_segment();
  endtask

  task automatic compare_events(input string tag);
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    check($sformatf("%s_count", tag), N'(obs_q.size()), N'(exp_q.size()));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_kind%0d", tag, i), N'(obs_q[i].is_err), N'(exp_q[i].is_err));
      if (!exp_q[i].is_err)
        check($sformatf("%s_frame%0d", tag, i), obs_q[i].frame, exp_q[i].frame);
    end
  endtask

  task automatic lock_and_receive(input bit wide, input string tag);
    logic [N-1:0] ref_frame = '0;
    int sync_idx;
    for (int k = 0; k < int'(G_SLOTS); k++)
      ref_frame[N-1-k*G_BITS -: G_BITS] = G_BITS'(16'hA000 + k);
    do_reset();
    push_rand(5);
    push_sync();
    sync_idx = din_q.size() - 1;
    push_frame(ref_frame, 1'b1);
    build_fclk(wide);
    compute_expect();
    drive_range(0, sync_idx);
    settle();
    check({tag, "_locked_after_first_fs"}, N'(out_locked), N'(1));
    check({tag, "_no_strobe_after_first_fs"}, N'(obs_q.size()), N'(0));
    drive_range(sync_idx + 1, din_q.size() - 1);
    settle();
    compare_events(tag);
    check({tag, "_frames"}, out_frames, ref_frame);
  endtask

  initial begin
    logic [N-1:0] d1;
    logic [N-1:0] d3;
    int idx;

    // Reset values
    #22;
    check("rst_frames", out_frames, '0);
    check("rst_strobe", N'(out_frame_strobe), N'(0));
    check("rst_locked", N'(out_locked), N'(0));
    check("rst_error", N'(out_error), N'(0));

    // Lock and receive, with 1-bit and 50%-duty fclk
    lock_and_receive(1'b0, "lr_narrow");
    lock_and_receive(1'b1, "lr_wide");

    // Back-to-back frames
    do_reset();
    push_sync();
    for (int i = 0; i < 10; i++) push_frame(rand_frame(), 1'b1);
    build_fclk(1'b0);
    compute_expect();
    drive_range(0, din_q.size() - 1);
    settle();
    compare_events("b2b");
    for (int i = 1; i < stb_t.size(); i++)
      check($sformatf("b2b_spacing%0d", i), N'(stb_t[i] - stb_t[i-1]), N'(N * T_SCLK));

    // Early sync after 100 bits
    do_reset();
    push_sync();
    push_rand(99);
    push_sync();
    idx = din_q.size() - 1;
    push_frame(rand_frame(), 1'b1);
    build_fclk(1'b0);
    compute_expect();
    drive_range(0, idx);
    settle();
    check("early_locked", N'(out_locked), N'(1));
    check("early_error_seen", N'(obs_q.size()), N'(1));
    drive_range(idx + 1, din_q.size() - 1);
    settle();
    compare_events("early");

    // Missing sync at the end of a frame
    do_reset();
    d1 = rand_frame();
    d3 = rand_frame();
    push_sync();
    push_frame(d1, 1'b1);
    push_frame(rand_frame(), 1'b0);
    idx = din_q.size() - 1;
    push_rand(5);
    push_sync();
    push_frame(d3, 1'b1);
    build_fclk(1'b0);
    compute_expect();
    drive_range(0, idx);
    settle();
    check("miss_unlocked", N'(out_locked), N'(0));
    check("miss_frames_held", out_frames, d1);
    drive_range(idx + 1, din_q.size() - 1);
    settle();
    compare_events("miss");
    check("miss_relock_frames", out_frames, d3);

    // Reset in the middle of a frame
    do_reset();
    d1 = rand_frame();
    push_sync();
    push_frame(d1, 1'b1);
    push_rand(60);
    build_fclk(1'b1);
    compute_expect();
    drive_range(0, din_q.size() - 1);
    compare_events("midrst_pre");
    check("midrst_locked_before", N'(out_locked), N'(1));
    in_rst_n = 1'b0;
    in_sclk  = 1'b0;
    in_fclk  = 1'b0;
    in_din   = 1'b0;
    #1;
    check("midrst_frames", out_frames, '0);
    check("midrst_locked", N'(out_locked), N'(0));
    check("midrst_strobe", N'(out_frame_strobe), N'(0));
    check("midrst_error", N'(out_error), N'(0));
    #39;
    in_rst_n = 1'b1;
    #40;
    new_segment();
    d3 = rand_frame();
    push_sync();
    push_frame(d3, 1'b1);
    build_fclk(1'b0);
    compute_expect();
    drive_range(0, 0);
    settle();
    check("midrst_relock", N'(out_locked), N'(1));
    check("midrst_no_strobe", N'(obs_q.size()), N'(0));
    drive_range(1, din_q.size() - 1);
    settle();
    compare_events("midrst_post");
    check("midrst_post_frames", out_frames, d3);

    // Pulse shape over the whole run
    check("strobe_error_overlap", N'(both_cnt), N'(0));
    check("pulse_width", N'(wide_cnt), N'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
